// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code sweep controller:
//   - FSM state encoding (IDLE/RUN/PAUSE/DONE)
//   - gray_of():    binary -> Gray conversion, usable by benches and models
//   - is_one_hot(): true when exactly one bit of the argument is set
// Both helpers work on 32-bit zero-extended operands, so any WIDTH <= 32 fits.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_PAUSE = ST_PAUSE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    function automatic logic [31:0] gray_of(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit was set.
    function automatic logic is_one_hot(input logic [31:0] x);
        return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/gray_encoder.sv
// -----------------------------------------------------------------------------
// gray_encoder
// Purely combinational binary-to-Gray converter.
// Ports:
//   i_bin   in   WIDTH  binary value
//   o_gray  out  WIDTH  i_bin ^ (i_bin >> 1)
// -----------------------------------------------------------------------------
module gray_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_sweep_controller.sv
// -----------------------------------------------------------------------------
// gray_sweep_controller
// Steps a binary index from first_val to last_val (up or down, wrapping modulo
// 2^WIDTH), holding each code for DWELL clocks and publishing the binary/Gray
// pair with a one-clock valid strobe. Each step is checked to change exactly
// one Gray bit; any violation sets the sticky hop_err until the next start.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high; wins over everything
//   start      in   1      begin a sweep (IDLE only); samples dir/first/last
//   abort      in   1      return to IDLE from RUN/PAUSE, outputs hold
//   pause      in   1      level; freezes dwell count and outputs
//   dir        in   1      0 = up, 1 = down
//   first_val  in   WIDTH  first binary index
//   last_val   in   WIDTH  final binary index
//   bin_out    out  WIDTH  current binary index
//   gray_out   out  WIDTH  Gray code of bin_out
//   valid      out  1      pulse when a new code is presented
//   busy       out  1      high while in RUN or PAUSE
//   done       out  1      pulse after the final code's dwell expires
//   hop_err    out  1      sticky multi-bit/zero-bit hop flag
// -----------------------------------------------------------------------------
module gray_sweep_controller
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DWELL = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             dir,
    input  logic [WIDTH-1:0] first_val,
    input  logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             hop_err
);

    localparam int              CW       = $clog2(DWELL + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] IDX_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] r_last;
    logic             r_dir;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_hop_err;

    logic             w_load;
    logic             w_step;
    logic             w_tick;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_hop_bad;

    // Next-state decode: abort beats pause, pause beats dwell expiry.
    // A PAUSE state with pause low behaves like RUN on that same edge, so a
    // pause of N clocks stretches the current dwell by exactly N clocks.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_tick       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (pause) begin
                    w_next_state = ST_PAUSE;
                end else if (r_count == CNT_LAST) begin
                    if (r_bin == r_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RUN;
                        w_step       = 1'b1;
                    end
                end else begin
                    w_next_state = ST_RUN;
                    w_tick       = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Next binary index: the start value on load, otherwise one step in the latched direction.
    always_comb begin
        if (w_load) begin
            w_next_bin = first_val;
        end else if (r_dir) begin
            w_next_bin = r_bin - IDX_ONE;
        end else begin
            w_next_bin = r_bin + IDX_ONE;
        end
    end

    gray_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_bin  (w_next_bin),
        .o_gray (w_next_gray)
    );

    assign w_hop_bad = ~is_one_hot(32'(w_next_gray ^ r_gray));

    // State, sweep datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_gray    <= '0;
            r_last    <= '0;
            r_dir     <= 1'b0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hop_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= w_load | w_step;
            r_busy  <= (w_next_state == ST_RUN) || (w_next_state == ST_PAUSE);
            r_done  <= (w_next_state == ST_DONE);
            if (w_load) begin
                r_bin     <= w_next_bin;
                r_gray    <= w_next_gray;
                r_last    <= last_val;
                r_dir     <= dir;
                r_count   <= '0;
                r_hop_err <= 1'b0;
            end else if (w_step) begin
                r_bin   <= w_next_bin;
                r_gray  <= w_next_gray;
                r_count <= '0;
                if (w_hop_bad) begin
                    r_hop_err <= 1'b1;
                end
            end else if (w_tick) begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign hop_err  = r_hop_err;

endmodule

// File: tb/tb_gray_sweep_controller.sv
module tb_gray_sweep_controller;

    localparam int WIDTH = 4;
    localparam int DWELL = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] first_val;
    logic [WIDTH-1:0] last_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic             hop_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         ecyc;
        logic [3:0] b;
        logic [3:0] g;
    } vrec_t;

    vrec_t vq[$];
    int    dq[$];

    gray_sweep_controller #(
        .WIDTH (WIDTH),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pause     (pause),
        .dir       (dir),
        .first_val (first_val),
        .last_val  (last_val),
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .hop_err   (hop_err)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge number m, cyc == m.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid code and done pulse together with the edge that produced it.
    always @(negedge clk) begin
        if (valid === 1'b1) vq.push_back('{cyc, bin_out, gray_out});
        if (done === 1'b1) dq.push_back(cyc);
    end

    function automatic logic [3:0] ref_gray(input int b);
        int v;
        v = b % 16;
        return 4'(v ^ (v >> 1));
    endfunction

    // One sweep: expected codes are first +/- k (mod 16), code k appears on edge
    // t0 + k*DWELL, delayed by the pause length for codes after the paused one.
    task automatic do_sweep(input string name, input int first, input int last, input bit d,
                            input int pk, input int off, input int plen, input bit poke_start);
        int n, t0, ps, e, shift, exp_e, b, nv;
        n  = d ? ((first - last + 16) % 16) + 1 : ((last - first + 16) % 16) + 1;
        ps = -1000;
        vq.delete();
        dq.delete();
        @(negedge clk);
        start     = 1'b1;
        abort     = 1'b0;
        pause     = 1'b0;
        dir       = d;
        first_val = 4'(first);
        last_val  = 4'(last);
        t0 = cyc + 1;
        if (plen > 0) ps = t0 + pk * DWELL + off;
        for (int c = 1; c <= n * DWELL + plen + 3; c++) begin
            @(negedge clk);
            e         = t0 + c;
            first_val = 4'($urandom_range(0, 15));
            last_val  = 4'($urandom_range(0, 15));
            dir       = 1'($urandom_range(0, 1));
            pause     = (e >= ps) && (e < ps + plen);
            start     = poke_start && pause;
            if (plen >= 2 && e == ps + plen - 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_in_pause got=%b want=1", name, busy);
                end
            end
        end
        pause = 1'b0;
        start = 1'b0;
        shift = (plen > 0) ? plen : 0;
        total++;
        if (vq.size() != n) begin
            bad++;
            $display("FAIL %s valid_count got=%0d want=%0d", name, vq.size(), n);
        end
        nv = (vq.size() < n) ? vq.size() : n;
        for (int k = 0; k < nv; k++) begin
            exp_e = t0 + k * DWELL + ((plen > 0 && k > pk) ? plen : 0);
            b     = d ? (first - k + 16) % 16 : (first + k) % 16;
            total++;
            if (vq[k].ecyc != exp_e || vq[k].b !== 4'(b) || vq[k].g !== ref_gray(b)) begin
                bad++;
                $display("FAIL %s code%0d got edge=%0d bin=%0d gray=%b want edge=%0d bin=%0d gray=%b",
                         name, k, vq[k].ecyc, vq[k].b, vq[k].g, exp_e, b, ref_gray(b));
            end
        end
        total++;
        if (dq.size() != 1 || dq[0] != t0 + n * DWELL + shift) begin
            bad++;
            $display("FAIL %s done_pulse got count=%0d edge=%0d want count=1 edge=%0d", name,
                     dq.size(), (dq.size() > 0) ? dq[0] : -1, t0 + n * DWELL + shift);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || bin_out !== 4'(last) ||
            gray_out !== ref_gray(last) || hop_err !== 1'b0) begin
            bad++;
            $display("FAIL %s end_state got busy=%b done=%b valid=%b bin=%0d gray=%b hop=%b want 0 0 0 %0d %b 0",
                     name, busy, done, valid, bin_out, gray_out, hop_err, last, ref_gray(last));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            abort     = 1'($urandom_range(0, 1));
            pause     = 1'($urandom_range(0, 1));
            dir       = 1'($urandom_range(0, 1));
            first_val = 4'($urandom_range(0, 15));
            last_val  = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        total++;
        if (bin_out !== 4'd0 || gray_out !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || hop_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got bin=%0d gray=%b v=%b busy=%b done=%b hop=%b want all 0",
                     bin_out, gray_out, valid, busy, done, hop_err);
        end
        start = 1'b0; abort = 1'b0; pause = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", busy, valid);
        end
    endtask

    task automatic test_full_up();
        do_sweep("full_up", 0, 15, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_sweep("wrap", 14, 1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_down();
        do_sweep("down", 3, 0, 1'b1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_pause();
        do_sweep("pause", 0, 7, 1'b0, 5, 4, 5, 1'b1);
    endtask

    task automatic test_abort_reset();
        int t0;
        vq.delete();
        dq.delete();
        @(negedge clk);
        start = 1'b1; dir = 1'b0; first_val = 4'd0; last_val = 4'd15;
        t0 = cyc + 1;
        for (int c = 1; c <= 6 * DWELL + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == 6 * DWELL + 3);
        end
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || bin_out !== 4'd6 || gray_out !== 4'b0101 || vq.size() != 7) begin
            bad++;
            $display("FAIL abort_state got busy=%b valid=%b bin=%0d gray=%b valids=%0d want 0 0 6 0101 7",
                     busy, valid, bin_out, gray_out, vq.size());
        end
        repeat (2 * DWELL) @(negedge clk);
        total++;
        if (dq.size() != 0 || bin_out !== 4'd6 || busy !== 1'b0 || vq.size() != 7) begin
            bad++;
            $display("FAIL abort_hold got dones=%0d bin=%0d busy=%b valids=%0d want 0 6 0 7",
                     dq.size(), bin_out, busy, vq.size());
        end
        start = 1'b1; first_val = 4'd2; last_val = 4'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bin_out !== 4'd0 || gray_out !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || hop_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_sweep got bin=%0d gray=%b v=%b busy=%b done=%b hop=%b want all 0",
                     bin_out, gray_out, valid, busy, done, hop_err);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || bin_out !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_mid_reset got busy=%b bin=%0d want 0 0", busy, bin_out);
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; dir = 1'b0; first_val = 4'd5; last_val = 4'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b1 || valid !== 1'b1 || bin_out !== 4'd5 || gray_out !== 4'b0111) begin
            bad++;
            $display("FAIL start_with_abort got busy=%b valid=%b bin=%0d gray=%b want 1 1 5 0111",
                     busy, valid, bin_out, gray_out);
        end
        repeat (DWELL + 2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_with_abort_end got busy=%b want 0", busy);
        end
    endtask

    task automatic test_hop_fault();
        force dut.w_next_gray = 4'b0000;
        @(negedge clk);
        start = 1'b1; dir = 1'b0; first_val = 4'd9; last_val = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * DWELL + 3) @(negedge clk);
        total++;
        if (hop_err !== 1'b1 || gray_out !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hop_fault_set got hop=%b gray=%b busy=%b want 1 0000 0", hop_err, gray_out, busy);
        end
        release dut.w_next_gray;
        repeat (5) @(negedge clk);
        total++;
        if (hop_err !== 1'b1) begin
            bad++;
            $display("FAIL hop_sticky got hop=%b want 1", hop_err);
        end
    endtask

    task automatic test_single();
        do_sweep("single", 9, 9, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int f, len, l, pk, off, plen;
        bit d;
        for (int it = 0; it < 6; it++) begin
            f    = $urandom_range(0, 15);
            len  = $urandom_range(1, 6);
            d    = 1'($urandom_range(0, 1));
            l    = d ? (f - len + 1 + 16) % 16 : (f + len - 1) % 16;
            pk   = $urandom_range(0, len - 1);
            off  = $urandom_range(1, DWELL - 1);
            plen = $urandom_range(0, 4);
            do_sweep($sformatf("random%0d", it), f, l, d, pk, off, plen, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; dir = 1'b0;
        first_val = 4'd0; last_val = 4'd0;
        test_reset();
        test_full_up();
        test_wrap();
        test_down();
        test_pause();
        test_abort_reset();
        test_start_abort();
        test_hop_fault();
        test_single();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
